// File: rtl/alu_share_sched.sv
// Round-robin scheduler that time-shares one external registered ALU among NREQ requesters.
// Each accepted op walks IDLE -> ISSUE -> SETTLE -> DONE and returns a tagged response in DONE.
module alu_share_sched #(
    parameter int NREQ = 2,
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_parity,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [2:0]           alu_op,
    output logic                 alu_ena,
    input  logic [W-1:0]         alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_parity,
    output logic                 busy,
    output logic [CNTW-1:0]      ops_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_rr_ptr;
    logic [1:0]      r_id;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;

    logic [1:0]      r_rsp_id;
    logic [W-1:0]    r_rsp_result;
    logic            r_rsp_carry;
    logic            r_rsp_parity;
    logic [CNTW-1:0] r_ops_done;

    logic            w_grant_any;
    logic [1:0]      w_grant_idx;
    logic [NREQ-1:0] w_grant_oh;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [2:0]      w_sel_op;
    logic            w_accept;
    logic            w_in_done;
    logic            w_carry_live;

    // Two passes give wrap-around priority: indices above the pointer first, then the rest.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_op    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_grant_any && req_valid[i] && (i > 32'(r_rr_ptr))) begin
                w_grant_any   = 1'b1;
                w_grant_idx   = 2'(i);
                w_grant_oh[i] = 1'b1;
                w_sel_a       = req_a[i*W +: W];
                w_sel_b       = req_b[i*W +: W];
                w_sel_op      = req_op[i*3 +: 3];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_grant_any && req_valid[i] && (i <= 32'(r_rr_ptr))) begin
                w_grant_any   = 1'b1;
                w_grant_idx   = 2'(i);
                w_grant_oh[i] = 1'b1;
                w_sel_a       = req_a[i*W +: W];
                w_sel_b       = req_b[i*W +: W];
                w_sel_op      = req_op[i*3 +: 3];
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && ena && w_grant_any;
    assign w_in_done = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req_ready   = w_grant_oh;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 2'(NREQ - 1);
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
        end else if (w_accept) begin
            r_id <= w_grant_idx;
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_op <= w_sel_op;
        end else if (w_in_done) begin
            r_rr_ptr <= r_id;
        end
    end

    // Carry out of the ALU is only meaningful for ADD/SUB; other ops leave it stale.
    assign w_carry_live = alu_carry && ((r_op == 3'b000) || (r_op == 3'b001));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_parity <= 1'b0;
            r_ops_done   <= '0;
        end else if (w_in_done) begin
            r_rsp_id     <= r_id;
            r_rsp_result <= alu_result;
            r_rsp_carry  <= w_carry_live;
            r_rsp_parity <= alu_parity;
            r_ops_done   <= r_ops_done + 1'b1;
        end
    end

    // Live ALU values during DONE; the registered copies hold them afterwards.
    assign rsp_valid  = w_in_done;
    assign rsp_id     = w_in_done ? r_id         : r_rsp_id;
    assign rsp_result = w_in_done ? alu_result   : r_rsp_result;
    assign rsp_carry  = w_in_done ? w_carry_live : r_rsp_carry;
    assign rsp_parity = w_in_done ? alu_parity   : r_rsp_parity;

    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_op   = r_op;
    assign alu_ena  = (r_state != S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign ops_done = r_ops_done;

endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: behavioural ALU, scoreboard of expected responses pushed at grant,
// directed cases for arithmetic flags, ena gating, mid-op reset, round robin and counter wrap.
module tb_alu_share_sched;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int CNTW = 8;
    localparam int NOPS = 270;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ena;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [NREQ*3-1:0]    req_op;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [W-1:0]         rsp_result;
    logic                 rsp_carry;
    logic                 rsp_parity;
    logic [W-1:0]         alu_a;
    logic [W-1:0]         alu_b;
    logic [2:0]           alu_op;
    logic                 alu_ena;
    logic [W-1:0]         alu_result;
    logic                 alu_carry;
    logic                 alu_parity;
    logic                 busy;
    logic [CNTW-1:0]      ops_done;

    alu_share_sched #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_parity (rsp_parity),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_ena    (alu_ena),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_parity (alu_parity),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    // Registered ALU: outputs clear while ena is low, parity lags the result by one cycle.
    // Carry for logic ops is a junk value so that masking in the scheduler matters.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            alu_carry  <= 1'b0;
            alu_parity <= 1'b0;
        end else if (!alu_ena) begin
            alu_result <= '0;
            alu_carry  <= 1'b0;
            alu_parity <= 1'b0;
        end else begin
            alu_parity <= ^alu_result;
            case (alu_op)
                3'd0: {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
                3'd1: {alu_carry, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
                3'd2: begin alu_result <= alu_a & alu_b; alu_carry <= alu_a[0] | alu_b[0]; end
                3'd3: begin alu_result <= alu_a | alu_b; alu_carry <= alu_a[0] | alu_b[0]; end
                3'd4: begin alu_result <= alu_a ^ alu_b; alu_carry <= alu_a[0] | alu_b[0]; end
                3'd5: begin alu_result <= ~alu_a;        alu_carry <= alu_a[0] | alu_b[0]; end
                3'd6: begin alu_result <= alu_a << 1;    alu_carry <= alu_a[0] | alu_b[0]; end
                default: begin alu_result <= alu_b;      alu_carry <= alu_a[0] | alu_b[0]; end
            endcase
        end
    end

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] res;
        logic         carry;
        logic         par;
        int unsigned  cyc;
    } exp_t;

    exp_t            sb[$];
    int              grant_log[$];
    int              checks   = 0;
    int              failures = 0;
    int unsigned     cyc      = 0;
    int              rsp_count = 0;
    logic [CNTW-1:0] exp_ops  = '0;
    logic [W-1:0]    last_res;
    logic            last_carry;
    logic            last_par;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input int unsigned c);
        exp_t       e;
        logic [W:0] s;
        case (op)
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} - {1'b0, b};
            3'd2:    s = {1'b0, a & b};
            3'd3:    s = {1'b0, a | b};
            3'd4:    s = {1'b0, a ^ b};
            3'd5:    s = {1'b0, ~a};
            3'd6:    s = {1'b0, a[W-2:0], 1'b0};
            default: s = {1'b0, b};
        endcase
        e.id    = 2'(id);
        e.res   = s[W-1:0];
        e.carry = (op == 3'd0 || op == 3'd1) ? s[W] : 1'b0;
        e.par   = ^s[W-1:0];
        e.cyc   = c;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                check("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
                check("ready_only_idle", 32'(busy), 0);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        sb.push_back(model(i, req_a[i*W +: W], req_b[i*W +: W], req_op[i*3 +: 3], cyc));
                        grant_log.push_back(i);
                    end
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                    check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                    check("rsp_parity", 32'(rsp_parity), 32'(e.par));
                    check("rsp_parity_xor", 32'(rsp_parity), 32'(^rsp_result));
                    check("rsp_latency", cyc - e.cyc, 3);
                    check("ops_done", 32'(ops_done), 32'(exp_ops));
                    exp_ops    = exp_ops + 1'b1;
                    last_res   = rsp_result;
                    last_carry = rsp_carry;
                    last_par   = rsp_parity;
                    rsp_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise one request, wait for its grant, then drop it and scramble its operands.
    task automatic request(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit got;
        got = 0;
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_op[id*3 +: 3] = op;
        req_valid[id]     = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                break;
            end
        end
        check("grant_seen", 32'(got), 1);
        tick();
        req_valid[id]     = 1'b0;
        req_a[id*W +: W]  = W'($urandom);
        req_b[id*W +: W]  = W'($urandom);
        req_op[id*3 +: 3] = 3'($urandom);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !busy) break;
        end
        check("drain_pending", sb.size(), 0);
        check("drain_idle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_before;
        int start;
        int bad;
        rst_n     = 1'b0;
        ena       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (3) tick();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_alu_ena", 32'(alu_ena), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ops_done", 32'(ops_done), 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick();

        request(0, 4'h7, 4'h9, 3'd0);
        wait_drain();
        check("add_result", 32'(last_res), 32'h0);
        check("add_carry", 32'(last_carry), 1);
        check("add_parity", 32'(last_par), 0);

        request(1, 4'h3, 4'h5, 3'd1);
        wait_drain();
        check("sub_result", 32'(last_res), 32'hE);
        check("sub_borrow", 32'(last_carry), 1);
        check("sub_parity", 32'(last_par), 1);

        request(0, 4'h7, 4'h9, 3'd0);
        wait_drain();
        request(1, 4'hF, 4'h6, 3'd2);
        wait_drain();
        check("and_result", 32'(last_res), 32'h6);
        check("and_carry_masked", 32'(last_carry), 0);
        check("idle_alu_a_hold", 32'(alu_a), 32'hF);
        check("idle_alu_b_hold", 32'(alu_b), 32'h6);
        check("idle_alu_op_hold", 32'(alu_op), 2);
        check("idle_rsp_hold", 32'(rsp_result), 32'h6);
        check("idle_rsp_valid", 32'(rsp_valid), 0);

        // ena low blocks grants even with a valid request pending
        ena           = 1'b0;
        req_a[W-1:0]  = 4'h2;
        req_b[W-1:0]  = 4'h2;
        req_op[2:0]   = 3'd3;
        req_valid[0]  = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("ena_block", 32'(req_ready), 0);
        end
        tick();
        ena = 1'b1;
        request(0, 4'h2, 4'hC, 3'd3);
        wait_drain();

        // ena dropped during SETTLE: op still completes
        cnt_before = rsp_count;
        request(1, 4'h9, 4'h8, 3'd0);
        tick();
        check("settle_busy", 32'(busy), 1);
        ena = 1'b0;
        wait_drain();
        check("ena_drop_rsp", rsp_count - cnt_before, 1);
        ena = 1'b1;

        // reset during SETTLE of requester 1 after requester 0 was last served
        request(0, 4'h2, 4'h3, 3'd0);
        wait_drain();
        cnt_before = rsp_count;
        request(1, 4'h5, 4'h5, 3'd4);
        tick();
        check("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        sb.delete();
        exp_ops = '0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_rsp_result", 32'(rsp_result), 0);
        check("mid_rst_alu_ena", 32'(alu_ena), 0);
        check("mid_rst_alu_a", 32'(alu_a), 0);
        check("mid_rst_alu_b", 32'(alu_b), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ops_done", 32'(ops_done), 0);
        repeat (3) tick();
        check("mid_rst_no_rsp", rsp_count - cnt_before, 0);
        rst_n = 1'b1;
        tick();

        // both requesters held valid with operands changing every cycle
        start     = grant_log.size();
        req_valid = '1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        check("post_reset_grant", 32'(req_ready), 32'b01);
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (grant_log.size() - start >= NOPS) break;
            req_a  = (NREQ*W)'($urandom);
            req_b  = (NREQ*W)'($urandom);
            req_op = (NREQ*3)'($urandom);
        end
        req_valid = '0;
        check("rr_grant_count", grant_log.size() - start, NOPS);
        wait_drain();
        bad = 0;
        for (int k = start + 1; k < grant_log.size(); k++) begin
            if (grant_log[k] == grant_log[k-1]) bad++;
        end
        check("rr_alternate", bad, 0);
        check("rr_first", grant_log[start], 0);
        check("ops_wrap", 32'(ops_done), NOPS % 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
